// File: rtl/mp_addsub_if.sv
// mp_addsub_if: start/done handshake and operand/result bus of the multi-precision add/sub sequencer
// Ports: start/op/cin/x/y driven by the requester (master); busy/done/r/cout/ovf (and zf when
// MP_ADDSUB_ZERO_EN is defined) driven by the sequencer (slave).
interface mp_addsub_if #(parameter int NBYTES = 4) ();
  localparam int W = 8 * NBYTES;
  logic start, op, cin, busy, done, cout, ovf;
  logic [W-1:0] x, y, r;
`ifdef MP_ADDSUB_ZERO_EN
  logic zf;
  modport master (output start, op, cin, x, y, input busy, done, r, cout, ovf, zf);
  modport slave (input start, op, cin, x, y, output busy, done, r, cout, ovf, zf);
`else
  modport master (output start, op, cin, x, y, input busy, done, r, cout, ovf);
  modport slave (input start, op, cin, x, y, output busy, done, r, cout, ovf);
`endif
endinterface

// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: W=8*NBYTES add/subtract done one byte per cycle on a shared 8-bit add/sub unit
// Ports: clk, rst (async, active-high); bus (mp_addsub_if.slave): start/op/cin/x/y in,
// busy/done/r/cout/ovf out. Defining MP_ADDSUB_ZERO_EN adds bus.zf (all result bytes zero).
module mp_addsub_seq #(
  parameter int NBYTES = 4,
  parameter int CW = 3
) (
  input logic clk,
  input logic rst,
  mp_addsub_if.slave bus
);
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [NBYTES-1:0][7:0] xl, yl, rb;
  logic opl, c, co, last;
  logic [CW-1:0] k;
  logic [KW-1:0] kx;
  logic [7:0] xb, yb, sb;
  logic [8:0] sum;
`ifdef MP_ADDSUB_ZERO_EN
  logic za;
`endif
  assign kx = k[KW-1:0];
  assign xb = xl[kx];
  assign yb = yl[kx];
  // c is carry for add, borrow for sub; a borrow enters the adder inverted (x + ~y + ~b)
  assign sum = {1'b0, xb} + {1'b0, yb ^ {8{opl}}} + {8'b0, c ^ opl};
  assign sb = sum[7:0];
  assign co = sum[8];
  assign last = k == CW'(NBYTES - 1);
  assign bus.r = rb;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.cout <= 1'b0;
      bus.ovf <= 1'b0;
      rb <= '0;
      xl <= '0;
      yl <= '0;
      opl <= 1'b0;
      c <= 1'b0;
      k <= '0;
`ifdef MP_ADDSUB_ZERO_EN
      za <= 1'b0;
      bus.zf <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          xl <= bus.x;
          yl <= bus.y;
          opl <= bus.op;
          c <= bus.cin;
          k <= '0;
          rb <= '0;
          bus.busy <= 1'b1;
          state <= RUN;
`ifdef MP_ADDSUB_ZERO_EN
          za <= 1'b1;
          bus.zf <= 1'b0;
`endif
        end
        RUN: begin
          rb[kx] <= sb;
          c <= co ^ opl;
          k <= k + 1'b1;
`ifdef MP_ADDSUB_ZERO_EN
          za <= za & ~|sb;
`endif
          if (last) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            bus.cout <= co ^ opl;
            // xb/yb hold the MSB byte here; operand signs equal (after sub inversion) but result sign differs
            bus.ovf <= (xb[7] == (yb[7] ^ opl)) && (sb[7] != xb[7]);
`ifdef MP_ADDSUB_ZERO_EN
            bus.zf <= za & ~|sb;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
